// File: rtl/npc_rf_pkg.sv
// Shared constants and helpers for the NPC integer register file.
package npc_rf_pkg;

  localparam int unsigned NREGS_RV32E = 16;
  localparam int unsigned NREGS_RV32I = 32;
  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned NREGS_DEF   = NREGS_RV32E;
  localparam int unsigned ZERO_REG    = 0;

  function automatic int unsigned rf_aw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: reservation, writeback clear, flush and issue_ready.
module regfile_scoreboard
  import npc_rf_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             issue_ready,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_d;

  assign busy = {busy_q, 1'b0};

  // A writeback to the requested register frees it this cycle, so the
  // new owner may reserve it without waiting for the busy bit to drop.
  always_comb begin
    issue_ready = 1'b0;
    if (!flush) begin
      issue_ready = (issue_rd == AW'(ZERO_REG)) || !busy[issue_rd] ||
                    (wen && (waddr == issue_rd));
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (issue_valid && issue_ready && (issue_rd == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wen && (waddr == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with write-ownership scoreboard and optional bypass.
module regfile_sb
  import npc_rf_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned BYPASS = 1,
  parameter  int unsigned DEBUG  = 0,
  localparam int unsigned AW     = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_id,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_ready,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                flush
);

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .wen        (wen),
    .waddr      (waddr),
    .flush      (flush),
    .busy       (busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wen && (waddr != AW'(ZERO_REG))) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   id;
    logic [XLEN-1:0] data;
    logic            ready;

    assign id = rs_id[k*AW +: AW];

    always_comb begin
      data  = '0;
      ready = 1'b1;
      if (id == AW'(ZERO_REG)) begin
        data  = '0;
        ready = 1'b1;
      end else if ((BYPASS != 0) && wen && (waddr == id)) begin
        data  = wdata;
        ready = 1'b1;
      end else begin
        data  = regs[id];
        ready = !busy[id];
      end
    end

    assign rs_data[k*XLEN +: XLEN] = data;
    assign rs_ready[k]             = ready;
  end

  // Flattened array view (x0 slot reads 0) for hierarchical dumps in debug builds.
  if (DEBUG != 0) begin : g_debug
    logic [NREGS*XLEN-1:0] dump;
    always_comb begin
      dump = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
        dump[i*XLEN +: XLEN] = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs a model.
module tb_regfile_sb;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: 16 regs, 2 ports, bypass on
  logic [7:0]  rs_id0;
  logic [63:0] rs_data0;
  logic [1:0]  rs_ready0;
  logic        issue_valid0, issue_ready0, wen0, flush0;
  logic [3:0]  issue_rd0, waddr0;
  logic [31:0] wdata0;

  // Instance 1: 32 regs, 3 ports, bypass off
  logic [14:0] rs_id1;
  logic [95:0] rs_data1;
  logic [2:0]  rs_ready1;
  logic        issue_valid1, issue_ready1, wen1, flush1;
  logic [4:0]  issue_rd1, waddr1;
  logic [31:0] wdata1;

  regfile_sb #(.XLEN(32), .NREGS(16), .NRD(2), .BYPASS(1)) u_rf16 (
    .clk(clk), .rst(rst), .rs_id(rs_id0), .rs_data(rs_data0), .rs_ready(rs_ready0),
    .issue_valid(issue_valid0), .issue_rd(issue_rd0), .issue_ready(issue_ready0),
    .wen(wen0), .waddr(waddr0), .wdata(wdata0), .flush(flush0)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(3), .BYPASS(0)) u_rf32 (
    .clk(clk), .rst(rst), .rs_id(rs_id1), .rs_data(rs_data1), .rs_ready(rs_ready1),
    .issue_valid(issue_valid1), .issue_rd(issue_rd1), .issue_ready(issue_ready1),
    .wen(wen1), .waddr(waddr1), .wdata(wdata1), .flush(flush1)
  );

  // Reference model: architectural contents and ownership per register
  logic [31:0] m0_regs [16];
  logic        m0_busy [16];
  logic [31:0] m1_regs [32];
  logic        m1_busy [32];

  function automatic logic [31:0] exp0_data(input logic [3:0] id);
    if (id == 0) return 32'h0;
    if (wen0 && waddr0 == id) return wdata0;
    return m0_regs[id];
  endfunction

  function automatic logic exp0_ready(input logic [3:0] id);
    if (id == 0) return 1'b1;
    if (wen0 && waddr0 == id) return 1'b1;
    return !m0_busy[id];
  endfunction

  function automatic logic exp0_iready();
    if (flush0) return 1'b0;
    return (issue_rd0 == 0) || !m0_busy[issue_rd0] || (wen0 && waddr0 == issue_rd0);
  endfunction

  function automatic logic [31:0] exp1_data(input logic [4:0] id);
    if (id == 0) return 32'h0;
    return m1_regs[id];
  endfunction

  function automatic logic exp1_ready(input logic [4:0] id);
    if (id == 0) return 1'b1;
    return !m1_busy[id];
  endfunction

  function automatic logic exp1_iready();
    if (flush1) return 1'b0;
    return (issue_rd1 == 0) || !m1_busy[issue_rd1] || (wen1 && waddr1 == issue_rd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m0_regs[i] = 0; m0_busy[i] = 0; end
    for (int i = 0; i < 32; i++) begin m1_regs[i] = 0; m1_busy[i] = 0; end
  endtask

  // Apply one clock edge to the model: writeback, then reservation, then flush overrides.
  task automatic model_edge();
    logic ir0, ir1;
    ir0 = exp0_iready();
    ir1 = exp1_iready();
    if (wen0 && waddr0 != 0) begin m0_regs[waddr0] = wdata0; m0_busy[waddr0] = 0; end
    if (issue_valid0 && ir0 && issue_rd0 != 0) m0_busy[issue_rd0] = 1;
    if (flush0) for (int i = 0; i < 16; i++) m0_busy[i] = 0;
    if (wen1 && waddr1 != 0) begin m1_regs[waddr1] = wdata1; m1_busy[waddr1] = 0; end
    if (issue_valid1 && ir1 && issue_rd1 != 0) m1_busy[issue_rd1] = 1;
    if (flush1) for (int i = 0; i < 32; i++) m1_busy[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle0();
    rs_id0 = '0; issue_valid0 = 0; issue_rd0 = '0; wen0 = 0; waddr0 = '0; wdata0 = '0; flush0 = 0;
  endtask

  task automatic idle1();
    rs_id1 = '0; issue_valid1 = 0; issue_rd1 = '0; wen1 = 0; waddr1 = '0; wdata1 = '0; flush1 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle0(); idle1(); model_reset();
    rs_id0 = {4'd5, 4'd3};
    #2;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rs_data0[k*32 +: 32] !== 32'h0 || rs_ready0[k] !== 1'b1) begin
        bad++; $display("FAIL reset_port%0d got data=%h ready=%b exp data=0 ready=1", k, rs_data0[k*32 +: 32], rs_ready0[k]);
      end
    end
    total++;
    if (issue_ready0 !== 1'b1 || issue_ready1 !== 1'b1) begin
      bad++; $display("FAIL reset_issue_ready got %b/%b exp 1/1", issue_ready0, issue_ready1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    wen0 = 1; waddr0 = 4'd5; wdata0 = 32'hDEADBEEF;
    tick();
    idle0(); rs_id0 = {4'd0, 4'd5};
    #1;
    total++;
    if (rs_data0[31:0] !== exp0_data(4'd5)) begin
      bad++; $display("FAIL reset_prewrite got %h exp %h", rs_data0[31:0], exp0_data(4'd5));
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (rs_data0[31:0] !== 32'h0 || rs_ready0[0] !== 1'b1) begin
      bad++; $display("FAIL reset_async got data=%h ready=%b exp data=0 ready=1", rs_data0[31:0], rs_ready0[0]);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_x0();
    idle0();
    wen0 = 1; waddr0 = 4'd0; wdata0 = 32'h1234;
    #1;
    total++;
    if (rs_data0[31:0] !== 32'h0 || rs_ready0[0] !== 1'b1) begin
      bad++; $display("FAIL x0_write_bypass got data=%h ready=%b exp data=0 ready=1", rs_data0[31:0], rs_ready0[0]);
    end
    tick();
    idle0(); issue_valid0 = 1; issue_rd0 = 4'd0;
    #1;
    total++;
    if (issue_ready0 !== 1'b1) begin
      bad++; $display("FAIL x0_issue_ready got %b exp 1", issue_ready0);
    end
    tick();
    idle0();
    for (int id = 0; id < 16; id += 2) begin
      rs_id0 = {4'(id + 1), 4'(id)};
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rs_data0[k*32 +: 32] !== exp0_data(rs_id0[k*4 +: 4]) || rs_ready0[k] !== exp0_ready(rs_id0[k*4 +: 4])) begin
          bad++; $display("FAIL x0_no_busy reg%0d got data=%h ready=%b exp data=%h ready=%b", id + k,
                          rs_data0[k*32 +: 32], rs_ready0[k], exp0_data(rs_id0[k*4 +: 4]), exp0_ready(rs_id0[k*4 +: 4]));
        end
      end
    end
  endtask

  task automatic test_raw();
    idle0(); issue_valid0 = 1; issue_rd0 = 4'd7;
    #1;
    total++;
    if (issue_ready0 !== exp0_iready()) begin
      bad++; $display("FAIL raw_issue got %b exp %b", issue_ready0, exp0_iready());
    end
    tick();
    idle0(); rs_id0 = {4'd7, 4'd7};
    #1;
    total++;
    if (rs_ready0 !== 2'b00) begin
      bad++; $display("FAIL raw_busy got ready=%b exp 00", rs_ready0);
    end
    wen0 = 1; waddr0 = 4'd7; wdata0 = 32'hA5A5A5A5;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rs_data0[k*32 +: 32] !== 32'hA5A5A5A5 || rs_ready0[k] !== 1'b1) begin
        bad++; $display("FAIL raw_bypass port%0d got data=%h ready=%b exp data=a5a5a5a5 ready=1", k, rs_data0[k*32 +: 32], rs_ready0[k]);
      end
    end
    tick();
    wen0 = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rs_data0[k*32 +: 32] !== exp0_data(4'd7) || rs_ready0[k] !== exp0_ready(4'd7)) begin
        bad++; $display("FAIL raw_array port%0d got data=%h ready=%b exp data=%h ready=%b", k,
                        rs_data0[k*32 +: 32], rs_ready0[k], exp0_data(4'd7), exp0_ready(4'd7));
      end
    end
  endtask

  task automatic test_waw();
    idle0(); issue_valid0 = 1; issue_rd0 = 4'd3;
    tick();
    #1;
    total++;
    if (issue_ready0 !== 1'b0) begin
      bad++; $display("FAIL waw_blocked got %b exp 0", issue_ready0);
    end
    tick();
    wen0 = 1; waddr0 = 4'd3; wdata0 = $urandom;
    #1;
    total++;
    if (issue_ready0 !== 1'b1) begin
      bad++; $display("FAIL waw_handover got %b exp 1", issue_ready0);
    end
    tick();
    idle0(); rs_id0 = {4'd3, 4'd3};
    #1;
    total++;
    if (rs_ready0[0] !== 1'b0 || rs_data0[31:0] !== exp0_data(4'd3)) begin
      bad++; $display("FAIL waw_new_owner got data=%h ready=%b exp data=%h ready=0", rs_data0[31:0], rs_ready0[0], exp0_data(4'd3));
    end
    wen0 = 1; waddr0 = 4'd3; wdata0 = 32'h0;
    tick();
    idle0();
  endtask

  task automatic test_flush();
    logic [3:0] ids [4];
    ids = '{4'd2, 4'd4, 4'd9, 4'd11};
    idle0();
    for (int i = 0; i < 3; i++) begin
      issue_valid0 = 1; issue_rd0 = ids[i];
      tick();
    end
    idle0(); rs_id0 = {4'd4, 4'd2};
    #1;
    total++;
    if (rs_ready0 !== 2'b00) begin
      bad++; $display("FAIL flush_pre_busy got ready=%b exp 00", rs_ready0);
    end
    flush0 = 1; issue_valid0 = 1; issue_rd0 = 4'd11; wen0 = 1; waddr0 = 4'd4; wdata0 = 32'h55;
    #1;
    total++;
    if (issue_ready0 !== 1'b0) begin
      bad++; $display("FAIL flush_issue_ready got %b exp 0", issue_ready0);
    end
    tick();
    idle0();
    for (int p = 0; p < 4; p += 2) begin
      rs_id0 = {ids[p+1], ids[p]};
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rs_ready0[k] !== 1'b1 || rs_data0[k*32 +: 32] !== exp0_data(ids[p+k])) begin
          bad++; $display("FAIL flush_after reg%0d got data=%h ready=%b exp data=%h ready=1", ids[p+k],
                          rs_data0[k*32 +: 32], rs_ready0[k], exp0_data(ids[p+k]));
        end
      end
    end
    total++;
    if (m0_regs[4] !== 32'h55) begin
      bad++; $display("FAIL flush_model_reg4 got %h exp 55", m0_regs[4]);
    end
  endtask

  task automatic test_param();
    idle1(); wen1 = 1; waddr1 = 5'd31; wdata1 = 32'h12345678;
    tick();
    idle1(); issue_valid1 = 1; issue_rd1 = 5'd31;
    tick();
    idle1(); wen1 = 1; waddr1 = 5'd31; wdata1 = 32'hFFFFFFFF; rs_id1 = {5'd31, 5'd31, 5'd31};
    issue_rd1 = 5'd31;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rs_data1[k*32 +: 32] !== 32'h12345678 || rs_ready1[k] !== 1'b0) begin
        bad++; $display("FAIL param_same_cycle port%0d got data=%h ready=%b exp data=12345678 ready=0", k, rs_data1[k*32 +: 32], rs_ready1[k]);
      end
    end
    total++;
    if (issue_ready1 !== 1'b1) begin
      bad++; $display("FAIL param_issue_ready got %b exp 1", issue_ready1);
    end
    tick();
    wen1 = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rs_data1[k*32 +: 32] !== 32'hFFFFFFFF || rs_ready1[k] !== 1'b1) begin
        bad++; $display("FAIL param_next_cycle port%0d got data=%h ready=%b exp data=ffffffff ready=1", k, rs_data1[k*32 +: 32], rs_ready1[k]);
      end
    end
    idle1();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rs_id0 = 8'($urandom); issue_valid0 = 1'($urandom); issue_rd0 = 4'($urandom);
      wen0 = 1'($urandom); waddr0 = 4'($urandom); wdata0 = $urandom;
      flush0 = ($urandom_range(0, 15) == 0);
      rs_id1 = 15'($urandom); issue_valid1 = 1'($urandom); issue_rd1 = 5'($urandom);
      wen1 = 1'($urandom); waddr1 = 5'($urandom); wdata1 = $urandom;
      flush1 = ($urandom_range(0, 15) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rs_data0[k*32 +: 32] !== exp0_data(rs_id0[k*4 +: 4]) || rs_ready0[k] !== exp0_ready(rs_id0[k*4 +: 4])) begin
          bad++; $display("FAIL rand16 cyc%0d port%0d id=%0d got data=%h ready=%b exp data=%h ready=%b", n, k, rs_id0[k*4 +: 4],
                          rs_data0[k*32 +: 32], rs_ready0[k], exp0_data(rs_id0[k*4 +: 4]), exp0_ready(rs_id0[k*4 +: 4]));
        end
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (rs_data1[k*32 +: 32] !== exp1_data(rs_id1[k*5 +: 5]) || rs_ready1[k] !== exp1_ready(rs_id1[k*5 +: 5])) begin
          bad++; $display("FAIL rand32 cyc%0d port%0d id=%0d got data=%h ready=%b exp data=%h ready=%b", n, k, rs_id1[k*5 +: 5],
                          rs_data1[k*32 +: 32], rs_ready1[k], exp1_data(rs_id1[k*5 +: 5]), exp1_ready(rs_id1[k*5 +: 5]));
        end
      end
      total++;
      if (issue_ready0 !== exp0_iready() || issue_ready1 !== exp1_iready()) begin
        bad++; $display("FAIL rand_issue_ready cyc%0d got %b/%b exp %b/%b", n, issue_ready0, issue_ready1, exp0_iready(), exp1_iready());
      end
      tick();
    end
    idle0(); idle1();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_raw();
    test_waw();
    test_flush();
    test_param();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated write-ownership scoreboard for the pipelined NPC core. It generalises the fixed RV32E file to a configurable register count, data width and read-port count, and adds asynchronous clearing, optional writeback-to-read bypass, and per-register busy tracking. Decode uses the busy tracking to detect RAW and WAW hazards. It sits between decode/issue (reads, destination reservation) and writeback (register update).

## Interface

Parameters:

- XLEN, 32, data width in bits.
- NREGS, 16, architectural register count; 16 (RV32E) or 32 (RV32I). AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to matching read ports.

Ports:

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs_id  in  NRD*AW  read indices; port k is bits [k*AW +: AW].
- rs_data  out  NRD*XLEN  read data per port.
- rs_ready  out  NRD  per port: operand valid (not busy, or bypassed).
- issue_valid  in  1  decode reserves issue_rd this cycle.
- issue_rd  in  AW  destination being reserved.
- issue_ready  out  1  reservation may be accepted this cycle.
- wen  in  1  writeback strobe.
- waddr  in  AW  writeback destination.
- wdata  in  XLEN  writeback data.
- flush  in  1  pipeline flush; drops all reservations.

## Operation

- State:
  - regs[1..NREGS-1], each XLEN wide.
  - busy[1..NREGS-1].
  - Register 0 has no storage.
- Reset (rst=0, asynchronous): every regs entry and busy bit go to 0 immediately. The outputs are combinational from this state, so after reset: rs_data=0, rs_ready=all 1s, issue_ready=1.
- Read port k:
  - If rs_id_k==0: data 0, ready 1.
  - Else if BYPASS and wen and waddr==rs_id_k: data wdata, ready 1.
  - Else: data regs[rs_id_k], ready !busy[rs_id_k].
  - With BYPASS=0, ready is !busy[rs_id_k] even when a matching writeback is in progress.
- Write:
  - On a clock edge with wen and waddr!=0, regs[waddr] <= wdata and busy[waddr] <= 0.
  - A write to register 0 is ignored.
  - A write to a non-busy register is legal and updates data.
- issue_ready:
  - 1 when issue_rd==0, or !busy[issue_rd], or (wen and waddr==issue_rd).
  - Forced to 0 while flush=1.
- Reservation: on a clock edge with issue_valid, issue_ready and issue_rd!=0, busy[issue_rd] <= 1.
  - issue_valid with issue_ready=0 has no effect; decode must hold and retry.
- Simultaneous writeback and issue to the same register: the data is written and busy ends at 1. The new owner wins.
- Flush: on a clock edge with flush=1, all busy bits clear.
  - A same-cycle issue is discarded.
  - A same-cycle wen still commits data.
- Priority per busy bit: flush clear > issue set > writeback clear.

## Timing

- Reads have zero latency (combinational). A write is visible through the array on the cycle after the edge; with BYPASS=1 it is also visible in the same cycle.
- Busy set takes effect the cycle after the issue edge. Busy clear takes effect the cycle after the writeback edge; with BYPASS=1, readiness is effectively same-cycle.
- issue_ready depends combinationally on issue_rd, wen, waddr and flush. No dependency on issue_valid is permitted, so there is no combinational loop.
- Reset asserted mid-operation aborts all reservations and zeroes data. Any write on that edge is lost.

## Structure

- Shared package npc_rf_pkg holds:
  - XLEN and NREGS defaults.
  - The AW function.
  - The ZERO_REG constant.
  - The RV32E/RV32I register-count constants.
- Sub-module regfile_scoreboard holds the busy bits, the reservation/clear/flush priority logic, and issue_ready generation.
- The top level holds the data array, read muxing, bypass, and the DEBUG register-dump hook.

## Test plan

- Reset:
  - Stimulus: assert rst=0 mid-cycle after writing regs[5]=0xDEADBEEF.
  - Required: rs_data for rs_id=5 reads 0 without waiting for a clock edge, and rs_ready=1.
- x0 handling:
  - Stimulus: wen, waddr=0, wdata=0x1234; then issue_valid with issue_rd=0.
  - Required: reading rs_id=0 gives 0 with ready=1, issue_ready stays 1, and no busy bit is set.
- RAW scoreboard:
  - Stimulus: issue rd=7; next cycle read rs_id=7.
  - Required: rs_ready=0.
  - Stimulus: then wen, waddr=7, wdata=0xA5A5A5A5 with BYPASS=1.
  - Required: rs_data=0xA5A5A5A5 and rs_ready=1 in the same cycle; the next cycle reads the same from the array.
- WAW and ownership:
  - Stimulus: issue rd=3; next cycle issue rd=3 again.
  - Required: issue_ready=0.
  - Stimulus: issue rd=3 in the same cycle as wen to 3.
  - Required: issue_ready=1 and busy[3]=1 afterwards.
- Flush:
  - Stimulus: busy set on 2, 4 and 9; flush=1 together with issue rd=11 and wen to 4 with 0x55.
  - Required: the next cycle shows all rs_ready=1, busy[11]=0 and regs[4]=0x55.
- Parametrisation:
  - Stimulus: NREGS=32, NRD=3, BYPASS=0; write 31=0xFFFFFFFF while it is busy, with all three ports reading 31.
  - Required: in the same cycle the ports show the old data with ready=0; the next cycle they show 0xFFFFFFFF with ready=1.
